// File: rtl/instr_fetch_unit.sv
// Instruction fetch responder: program counter, writable instruction memory and
// instruction register, plus a program-load port used before execution starts.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 128
) (
  input  logic              clk,
  input  logic              ResetN,
  input  logic              PC_Clr,
  input  logic              PC_Up,
  input  logic              IR_Id,
  input  logic              Prog_en,
  input  logic              Prog_wr,
  input  logic [DATA_W-1:0] Prog_data,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] PC,
  output logic              Ready,
  output logic [ADDR_W:0]   Prog_cnt,
  output logic              Prog_ovf
);

  typedef enum logic [1:0] {StIdle, StProg, StRun} state_e;

  localparam logic [ADDR_W:0]   CntMax = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CntOne = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PcOne  = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                ready_q, ready_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_rdata;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Combinational read port addressed by the current PC.
  assign mem_rdata = mem_q[pc_q];

  // Next-state logic for the load/run mode FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = Prog_en ? StProg : StRun;
      StProg:  state_d = Prog_en ? StProg : StRun;
      StRun:   state_d = Prog_en ? StProg : StRun;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: load-session bookkeeping in PROG, fetch actions in RUN.
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    mem_we    = 1'b0;
    mem_waddr = cnt_q[ADDR_W-1:0];
    ready_d   = (state_d == StRun);

    if (state_d == StProg && state_q != StProg) begin
      // New load session starts clean.
      pc_d  = '0;
      ir_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (state_q == StProg) begin
      if (Prog_wr) begin
        if (cnt_q < CntMax) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + CntOne;
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (state_d == StRun) begin
        pc_d = '0;
        ir_d = '0;
      end
    end else if (state_q == StRun) begin
      // IR samples memory at the pre-update PC, so a Fetch cycle gets the old word.
      if (IR_Id) begin
        ir_d = mem_rdata;
      end
      if (PC_Clr) begin
        pc_d = '0;
      end else if (PC_Up) begin
        pc_d = pc_q + PcOne;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
    end
  end

  // Instruction memory write port; deliberately not reset so a program survives ResetN.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= Prog_data;
    end
  end

  assign IR       = ir_q;
  assign PC       = pc_q;
  assign Ready    = ready_q;
  assign Prog_cnt = cnt_q;
  assign Prog_ovf = ovf_q;

endmodule
